coin_scheduler: RTL and testbench

- Owns the alive state of NUM_COINS coins.
- Once per frame, scans every coin through a single shared hitbox comparator, checking mario then luigi.
- Clears collected coins and credits the collecting player's score.
- Sits between the player position registers and the coin sprite/score display logic, and replaces the per-coin collision instances.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_scheduler_hitbox_overlap.sv | 34 +++
 rtl/coin_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_coin_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin scheduler: screen coordinate width,
// default hitbox thresholds, scan FSM encoding and an index-width helper.
package coin_pkg;

  localparam int SCREEN_COORD_W = 10;
  localparam int DEF_HIT_W      = 16;
  localparam int DEF_HIT_H      = 28;

  // Scan sequencer states: wait for a frame, test mario, test luigi, advance.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHK_M = 2'd1,
    CHK_L = 2'd2,
    NEXT  = 2'd3
  } scan_state_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/coin_scheduler_hitbox_overlap.sv
// Purely combinational axis-aligned overlap test between a player and a coin.
// Both sides are widened to 11 bits so a position near 1023 plus the
// threshold cannot wrap. Touching at exactly the threshold is not a hit.
module hitbox_overlap
  import coin_pkg::*;
#(
  parameter int HIT_W = DEF_HIT_W,
  parameter int HIT_H = DEF_HIT_H
) (
  input  logic [SCREEN_COORD_W-1:0] a_x_i,
  input  logic [SCREEN_COORD_W-1:0] a_y_i,
  input  logic [SCREEN_COORD_W-1:0] b_x_i,
  input  logic [SCREEN_COORD_W-1:0] b_y_i,
  output logic                      hit_o
);

  localparam int EW = SCREEN_COORD_W + 1;
  localparam logic [EW-1:0] W_EXT = EW'(HIT_W);
  localparam logic [EW-1:0] H_EXT = EW'(HIT_H);

  logic [EW-1:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x_i};
  assign ay = {1'b0, a_y_i};
  assign bx = {1'b0, b_x_i};
  assign by = {1'b0, b_y_i};

  // Overlap on both axes, strict inequality on each side.
  always_comb begin
    hit_o = (ax < bx + W_EXT) && (bx < ax + W_EXT) &&
            (ay < by + H_EXT) && (by < ay + H_EXT);
  end

endmodule

// File: rtl/coin_scheduler.sv
// Coin scheduler: owns the alive state of NUM_COINS coins and, once per
// frame, walks every coin through one shared hitbox comparator (mario first,
// then luigi), clearing collected coins and crediting saturating scores.
// Optional feature macro: COIN_RESPAWN_EN -- per-coin frame counters that
// revive a collected coin after RESPAWN_FRAMES frame edges.
//
// Frame handshake: a rising edge of frame_Clk (registered in the Clk domain)
// raises pending; IDLE consumes pending to start a scan. An edge arriving
// while a request is still pending (and not consumed that same cycle) is
// dropped and latches the sticky frame_overrun flag.
module coin_scheduler
  import coin_pkg::*;
#(
  parameter int NUM_COINS      = 4,
  parameter int HIT_W          = DEF_HIT_W,
  parameter int HIT_H          = DEF_HIT_H,
  parameter int SCORE_W        = 8,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                frame_Clk,
  input  logic [SCREEN_COORD_W-1:0]           mario_x,
  input  logic [SCREEN_COORD_W-1:0]           mario_y,
  input  logic [SCREEN_COORD_W-1:0]           luigi_x,
  input  logic [SCREEN_COORD_W-1:0]           luigi_y,
  input  logic [SCREEN_COORD_W*NUM_COINS-1:0] coin_x_flat,
  input  logic [SCREEN_COORD_W*NUM_COINS-1:0] coin_y_flat,
  output logic [NUM_COINS-1:0]                coin_alive,
  output logic [SCORE_W-1:0]                  mario_score,
  output logic [SCORE_W-1:0]                  luigi_score,
  output logic                                collect_pulse,
  output logic [3:0]                          collect_idx,
  output logic                                scan_busy,
  output logic                                frame_overrun
);

  localparam int CW = SCREEN_COORD_W;
  localparam int IW = idx_w(NUM_COINS);
  localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_COINS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  scan_state_t state_q, state_d;

  logic                 frame_q;
  logic                 frame_edge;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        mx_q, mx_d, my_q, my_d;
  logic [CW-1:0]        lx_q, lx_d, ly_q, ly_d;
  logic [NUM_COINS-1:0] alive_q, alive_d;
  logic [SCORE_W-1:0]   ms_q, ms_d, ls_q, ls_d;
  logic                 pulse_q, pulse_d;
  logic [3:0]           cidx_q, cidx_d;

  logic [CW-1:0]        coin_x_sel, coin_y_sel;
  logic [CW-1:0]        ply_x, ply_y;
  logic [NUM_COINS-1:0] sel_onehot;
  logic [NUM_COINS-1:0] live_gate;
  logic [NUM_COINS-1:0] respawn_set;
  logic [NUM_COINS-1:0] collect_onehot;
  logic                 coin_live;
  logic                 hit;
  logic                 chk_hit;
  logic                 checking;

  assign frame_edge = frame_Clk & ~frame_q;

  // Select the coin under test and its one-hot position from the flat buses.
  always_comb begin
    coin_x_sel = '0;
    coin_y_sel = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (idx_q == IW'(i)) begin
        coin_x_sel    = coin_x_flat[i*CW +: CW];
        coin_y_sel    = coin_y_flat[i*CW +: CW];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // The comparator sees luigi's snapshot only in CHK_L, mario's otherwise.
  assign ply_x = (state_q == CHK_L) ? lx_q : mx_q;
  assign ply_y = (state_q == CHK_L) ? ly_q : my_q;

  hitbox_overlap #(
    .HIT_W(HIT_W),
    .HIT_H(HIT_H)
  ) u_hitbox (
    .a_x_i(ply_x),
    .a_y_i(ply_y),
    .b_x_i(coin_x_sel),
    .b_y_i(coin_y_sel),
    .hit_o(hit)
  );

  assign checking       = (state_q == CHK_M) || (state_q == CHK_L);
  assign coin_live      = |(alive_q & live_gate & sel_onehot);
  assign chk_hit        = coin_live & hit;
  assign collect_onehot = sel_onehot & {NUM_COINS{checking & chk_hit}};

`ifdef COIN_RESPAWN_EN
  localparam int RW = $clog2(RESPAWN_FRAMES + 2);

  logic [RW-1:0]        cnt_q [NUM_COINS];
  logic [RW-1:0]        cnt_d [NUM_COINS];
  logic [NUM_COINS-1:0] mask_q, mask_d;

  // Respawn timers: load on collection, count frame edges while dead.
  always_comb begin
    respawn_set = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (collect_onehot[i]) begin
        cnt_d[i] = RW'(RESPAWN_FRAMES);
      end else if (frame_edge && !alive_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - RW'(1);
        if (cnt_q[i] == RW'(1)) respawn_set[i] = 1'b1;
      end
    end
  end

  // Coins revived mid-scan stay out of the running scan via this snapshot.
  always_comb begin
    mask_d = mask_q;
    if ((state_q == IDLE) && pending_q) mask_d = alive_q;
  end

  assign live_gate = mask_q;

  // Timer and scan-mask registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_COINS; i++) cnt_q[i] <= '0;
      mask_q <= '0;
    end else begin
      for (int i = 0; i < NUM_COINS; i++) cnt_q[i] <= cnt_d[i];
      mask_q <= mask_d;
    end
  end
`else
  // Without timers a collected coin stays dead; the parameter has no effect.
  assign live_gate   = {NUM_COINS{RESPAWN_FRAMES >= 0}};
  assign respawn_set = '0;
`endif

  // Frame request: raise pending on an edge, drop and flag a second one.
  always_comb begin
    pending_d = pending_q && (state_q != IDLE);
    overrun_d = overrun_q;
    if (frame_edge) begin
      if (pending_d) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: a mario hit skips the luigi check for that coin.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = CHK_M;
      CHK_M:   state_d = chk_hit ? NEXT : CHK_L;
      CHK_L:   state_d = NEXT;
      NEXT:    state_d = (idx_q == LAST_IDX) ? IDLE : CHK_M;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values: snapshot, credit, clear, advance.
  always_comb begin
    scan_busy = (state_q != IDLE);
    mx_d      = mx_q;
    my_d      = my_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    idx_d     = idx_q;
    ms_d      = ms_q;
    ls_d      = ls_q;
    alive_d   = (alive_q & ~collect_onehot) | respawn_set;
    pulse_d   = |collect_onehot;
    cidx_d    = (|collect_onehot) ? 4'(idx_q) : cidx_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          mx_d  = mario_x;
          my_d  = mario_y;
          lx_d  = luigi_x;
          ly_d  = luigi_y;
          idx_d = '0;
        end
      end
      CHK_M: begin
        if (chk_hit && (ms_q != SCORE_MAX)) ms_d = ms_q + SCORE_W'(1);
      end
      CHK_L: begin
        if (chk_hit && (ls_q != SCORE_MAX)) ls_d = ls_q + SCORE_W'(1);
      end
      NEXT: begin
        if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers; reset aborts any scan with no credit.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      lx_q      <= '0;
      ly_q      <= '0;
      alive_q   <= '1;
      ms_q      <= '0;
      ls_q      <= '0;
      pulse_q   <= 1'b0;
      cidx_q    <= '0;
    end else begin
      frame_q   <= frame_Clk;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      alive_q   <= alive_d;
      ms_q      <= ms_d;
      ls_q      <= ls_d;
      pulse_q   <= pulse_d;
      cidx_q    <= cidx_d;
    end
  end

  assign coin_alive    = alive_q;
  assign mario_score   = ms_q;
  assign luigi_score   = ls_q;
  assign collect_pulse = pulse_q;
  assign collect_idx   = cidx_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_coin_scheduler.sv
// Directed bench for coin_scheduler. A reference model predicts collections
// per frame and pushes the expected coin indices into exp_q; they are popped
// as collect_pulse appears. A 2-bit score makes saturation reachable.
module tb_coin_scheduler;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int MAXS = 3;
  localparam int HW   = 16;
  localparam int HH   = 28;
`ifdef COIN_RESPAWN_EN
  localparam int RF = 3;
`else
  localparam int RF = 60;
`endif

  logic            Clk;
  logic            Reset_n;
  logic            frame_Clk;
  logic [9:0]      mario_x, mario_y, luigi_x, luigi_y;
  logic [10*N-1:0] coin_x_flat, coin_y_flat;
  logic [N-1:0]    coin_alive;
  logic [SW-1:0]   mario_score, luigi_score;
  logic            collect_pulse;
  logic [3:0]      collect_idx;
  logic            scan_busy;
  logic            frame_overrun;

  int checks = 0;
  int errors = 0;

  logic [3:0]   exp_q[$];
  logic [N-1:0] m_alive;
  int           m_ms, m_ls;
  int           cx[N], cy[N];
  int           pmx, pmy, plx, ply;
`ifdef COIN_RESPAWN_EN
  int           m_cnt[N];
`endif

  coin_scheduler #(
    .NUM_COINS(N), .HIT_W(HW), .HIT_H(HH), .SCORE_W(SW), .RESPAWN_FRAMES(RF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_Clk(frame_Clk),
    .mario_x(mario_x), .mario_y(mario_y), .luigi_x(luigi_x), .luigi_y(luigi_y),
    .coin_x_flat(coin_x_flat), .coin_y_flat(coin_y_flat),
    .coin_alive(coin_alive), .mario_score(mario_score), .luigi_score(luigi_score),
    .collect_pulse(collect_pulse), .collect_idx(collect_idx),
    .scan_busy(scan_busy), .frame_overrun(frame_overrun)
  );

  // Clock and watchdog.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic set_mario(input int x, input int y);
    pmx = x; pmy = y; mario_x = 10'(x); mario_y = 10'(y);
  endtask

  task automatic set_luigi(input int x, input int y);
    plx = x; ply = y; luigi_x = 10'(x); luigi_y = 10'(y);
  endtask

  task automatic set_coin(input int i, input int x, input int y);
    cx[i] = x; cy[i] = y;
    coin_x_flat[i*10 +: 10] = 10'(x);
    coin_y_flat[i*10 +: 10] = 10'(y);
  endtask

  function automatic bit ovl(input int ax, input int ay, input int bx, input int by);
    return (ax < bx + HW) && (bx < ax + HW) && (ay < by + HH) && (by < ay + HH);
  endfunction

  task automatic model_reset();
    m_alive = '1; m_ms = 0; m_ls = 0;
    exp_q.delete();
`ifdef COIN_RESPAWN_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endtask

  task automatic model_edge();
`ifdef COIN_RESPAWN_EN
    for (int i = 0; i < N; i++) begin
      if (!m_alive[i] && m_cnt[i] > 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_alive[i] = 1'b1;
      end
    end
`endif
  endtask

  // Predict one scan: pushes expected indices, returns busy-cycle count.
  task automatic model_scan(output int busy);
    busy = 0;
    for (int i = 0; i < N; i++) begin
      if (m_alive[i] && ovl(pmx, pmy, cx[i], cy[i])) begin
        m_alive[i] = 1'b0;
        if (m_ms < MAXS) m_ms++;
        exp_q.push_back(4'(i));
        busy += 2;
`ifdef COIN_RESPAWN_EN
        m_cnt[i] = RF;
`endif
      end else begin
        if (m_alive[i] && ovl(plx, ply, cx[i], cy[i])) begin
          m_alive[i] = 1'b0;
          if (m_ls < MAXS) m_ls++;
          exp_q.push_back(4'(i));
`ifdef COIN_RESPAWN_EN
          m_cnt[i] = RF;
`endif
        end
        busy += 3;
      end
    end
  endtask

  task automatic frame_edge();
    @(negedge Clk); frame_Clk = 1'b1;
    @(negedge Clk); frame_Clk = 1'b0;
    model_edge();
  endtask

  // Follow one scan to completion, popping the scoreboard on each pulse.
  task automatic run_scan(input string tag, input int exp_busy);
    int t = 0;
    int b = 0;
    logic [3:0] e;
    while (scan_busy !== 1'b1 && t < 10) begin @(negedge Clk); t++; end
    chk({tag, "_start"}, 32'(scan_busy), 1);
    while (scan_busy === 1'b1 && b < 60) begin
      b++;
      if (collect_pulse === 1'b1) begin
        if (exp_q.size() == 0) chk({tag, "_extra_pulse"}, 32'(collect_pulse), 0);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_idx"}, 32'(collect_idx), 32'(e));
        end
      end
      @(negedge Clk);
    end
    chk({tag, "_end"}, 32'(scan_busy), 0);
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, b, exp_busy);
    chk({tag, "_missing_pulses"}, exp_q.size(), 0);
    chk({tag, "_pulse_low"}, 32'(collect_pulse), 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_alive"}, 32'(coin_alive), 32'(m_alive));
    chk({tag, "_mario"}, 32'(mario_score), m_ms);
    chk({tag, "_luigi"}, 32'(luigi_score), m_ls);
  endtask

  task automatic do_frame(input string tag);
    int b;
    frame_edge();
    model_scan(b);
    run_scan(tag, b);
    check_state(tag);
  endtask

  initial begin
    int b1, b2;
    Reset_n = 1'b0;
    frame_Clk = 1'b0;
    coin_x_flat = '0;
    coin_y_flat = '0;
    set_mario(100, 100);
    set_luigi(600, 600);
    set_coin(0, 110, 120);
    set_coin(1, 500, 400);
    set_coin(2, 200, 50);
    set_coin(3, 800, 300);
    model_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_alive", 32'(coin_alive), 32'hF);
    chk("rst_mario", 32'(mario_score), 0);
    chk("rst_luigi", 32'(luigi_score), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_overrun", 32'(frame_overrun), 0);
    chk("rst_pulse", 32'(collect_pulse), 0);
    chk("rst_idx", 32'(collect_idx), 0);

    // Mario collects coin0.
    do_frame("f1_mario_c0");

    // Both players on coin2: only mario is credited.
    set_mario(200, 50);
    set_luigi(200, 50);
    do_frame("f2_priority");

    // Threshold boundaries on x and y.
    set_mario(100, 100);
    set_luigi(600, 600);
    set_coin(3, 116, 100);
    do_frame("f3_dx16");
    set_coin(3, 115, 128);
    do_frame("f4_dy28");
    set_coin(3, 115, 127);
    do_frame("f5_inside");

    // Near the right edge: no wrap; score already saturated.
    set_mario(1020, 500);
    set_coin(1, 1015, 505);
    do_frame("f6_edge_sat");
    do_frame("f7_dead");

    // Two edges four cycles apart: exactly two scans.
    set_mario(400, 900);
    set_luigi(0, 0);
    frame_edge();
    model_scan(b1);
    repeat (4) @(negedge Clk);
    frame_edge();
    model_scan(b2);
    run_scan("two_edges_a", -1);
    run_scan("two_edges_b", b2);
    chk("two_edges_overrun", 32'(frame_overrun), 0);
    check_state("two_edges");

    // Three edges inside one scan: third is dropped, one extra scan runs.
    frame_edge();
    frame_edge();
    frame_edge();
    model_scan(b1);
    model_scan(b2);
    run_scan("three_edges_a", -1);
    run_scan("three_edges_b", b2);
    repeat (5) @(negedge Clk);
    chk("three_edges_no_more", 32'(scan_busy), 0);
    chk("three_edges_overrun", 32'(frame_overrun), 1);
    check_state("three_edges");

    // Reset in the middle of a scan.
    set_mario(100, 100);
    frame_edge();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    model_reset();
    chk("abort_busy", 32'(scan_busy), 0);
    chk("abort_overrun", 32'(frame_overrun), 0);
    chk("abort_pulse", 32'(collect_pulse), 0);
    check_state("abort");

    // Luigi collects coin1, then watch it across ten frames.
    set_mario(400, 900);
    set_luigi(1020, 500);
    do_frame("luigi_c1");
    set_luigi(0, 0);
    for (int f = 0; f < 10; f++) do_frame($sformatf("respawn_f%0d", f));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
